// File: rtl/capture_if.sv
// capture_if: bundles the sequencer's control, RAM address and dump handshake signals.
//   master modport: upstream/consumer side (drives run, wrt_smpl, triggered, trig_pos,
//                   dump_req, dump_rdy; observes everything else)
//   slave modport : capture_ctrl side (drives we, waddr, raddr, armed, capture_done,
//                   dump_vld, dump_done)
interface capture_if #(
  parameter int LOG2 = 9
) ();
  logic            run;
  logic            wrt_smpl;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            dump_req;
  logic            dump_rdy;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] raddr;
  logic            armed;
  logic            capture_done;
  logic            dump_vld;
  logic            dump_done;

  modport master (
    output run, wrt_smpl, triggered, trig_pos, dump_req, dump_rdy,
    input  we, waddr, raddr, armed, capture_done, dump_vld, dump_done
  );

  modport slave (
    input  run, wrt_smpl, triggered, trig_pos, dump_req, dump_rdy,
    output we, waddr, raddr, armed, capture_done, dump_vld, dump_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture/dump sequencer for one channel's sample RAM.
//   Captures samples into a circular buffer of ENTRIES locations, stops trig_pos
//   samples after a qualified trigger, then streams the buffer oldest-first through
//   a valid/ready handshake that accounts for the RAM's 1-cycle read latency.
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active high
//   bus (slave)  run/wrt_smpl/triggered/trig_pos/dump_req/dump_rdy in;
//                we (combinational), waddr, raddr, armed, capture_done,
//                dump_vld, dump_done out (registered)
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic     clk,
  input  logic     rst,
  capture_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPTURE  = 3'd1;
  localparam logic [2:0] S_POST     = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_DUMP_RD  = 3'd4;
  localparam logic [2:0] S_DUMP_VLD = 3'd5;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL = (LOG2 + 1)'(ENTRIES);

  function automatic logic [LOG2-1:0] wrap_inc(input logic [LOG2-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [LOG2-1:0] clamp_tp(input logic [LOG2-1:0] tp);
    return (tp > LAST) ? LAST : tp;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d;
  logic [LOG2-1:0] post_cnt_q, post_cnt_d;
  logic [LOG2-1:0] byte_cnt_q, byte_cnt_d;
  logic            armed_q, armed_d;
  logic            cap_done_q, cap_done_d;
  logic            dump_vld_q, dump_vld_d;
  logic            dump_done_q, dump_done_d;

  logic [LOG2-1:0] tp;
  logic [LOG2:0]   smpl_next;
  logic [LOG2-1:0] post_inc;
  logic            capturing;

  assign tp        = clamp_tp(bus.trig_pos);
  assign smpl_next = (smpl_cnt_q == FULL) ? FULL : smpl_cnt_q + 1'b1;
  assign post_inc  = post_cnt_q + 1'b1;
  assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    armed_d     = armed_q;
    cap_done_d  = cap_done_q;
    dump_vld_d  = dump_vld_q;
    dump_done_d = 1'b0;

    // run restarts from IDLE or mid-capture; a frozen or dumping buffer ignores it.
    if (bus.run && (state_q == S_IDLE || capturing)) begin
      state_d    = S_CAPTURE;
      waddr_d    = '0;
      smpl_cnt_d = '0;
      armed_d    = 1'b0;
      cap_done_d = 1'b0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (bus.wrt_smpl) begin
            waddr_d    = wrap_inc(waddr_q);
            smpl_cnt_d = smpl_next;
          end
          // Armed once the pre-trigger history plus the post-trigger tail fills the buffer.
          armed_d = armed_q | (({1'b0, tp} + smpl_cnt_d) >= FULL);
          // Only the registered armed qualifies a trigger, so the arming cycle's trigger is dropped.
          if (bus.triggered && armed_q) begin
            post_cnt_d = '0;
            if (tp == '0) begin
              state_d    = S_DONE;
              cap_done_d = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          if (bus.wrt_smpl) begin
            waddr_d    = wrap_inc(waddr_q);
            smpl_cnt_d = smpl_next;
            post_cnt_d = post_inc;
            if (post_inc == tp) begin
              state_d    = S_DONE;
              cap_done_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          // waddr already points at the oldest sample after the last wrap.
          if (bus.dump_req) begin
            raddr_d    = waddr_q;
            byte_cnt_d = '0;
            state_d    = S_DUMP_RD;
          end
        end
        S_DUMP_RD: begin
          // One idle cycle with raddr stable lets the RAM's registered read land.
          state_d    = S_DUMP_VLD;
          dump_vld_d = 1'b1;
        end
        S_DUMP_VLD: begin
          if (bus.dump_rdy) begin
            dump_vld_d = 1'b0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST) begin
              dump_done_d = 1'b1;
              cap_done_d  = 1'b0;
              state_d     = S_IDLE;
            end else begin
              raddr_d = wrap_inc(raddr_q);
              state_d = S_DUMP_RD;
            end
          end
        end
        S_IDLE:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      armed_q     <= 1'b0;
      cap_done_q  <= 1'b0;
      dump_vld_q  <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      armed_q     <= armed_d;
      cap_done_q  <= cap_done_d;
      dump_vld_q  <= dump_vld_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign bus.we           = bus.wrt_smpl && capturing;
  assign bus.waddr        = waddr_q;
  assign bus.raddr        = raddr_q;
  assign bus.armed        = armed_q;
  assign bus.capture_done = cap_done_q;
  assign bus.dump_vld     = dump_vld_q;
  assign bus.dump_done    = dump_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized bench for capture_ctrl with a sample RAM and a
// stream-level reference model (history of accepted samples, arm/post rules).
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  capture_if #(.LOG2(LOG2)) bus ();

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Sample RAM with registered read, as the RAMqueue behaves.
  logic [7:0] mem [ENTRIES];
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  int we_cnt   = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (bus.we) begin
      mem[bus.waddr] <= wdata;
      we_cnt <= we_cnt + 1;
    end
    rdata <= mem[bus.raddr];
    if (bus.dump_done) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 capturing, 2 frozen.
  int         m_n = 0;
  int         m_phase = 0;
  int         m_post = 0;
  int         tp_eff = 0;
  bit         m_armed = 1'b0;
  bit         m_post_active = 1'b0;
  bit         idx_data = 1'b0;
  logic [7:0] hist [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tp(input int tp);
    bus.trig_pos = tp[LOG2-1:0];
    tp_eff = (tp > ENTRIES - 1) ? ENTRIES - 1 : tp;
  endtask

  task automatic start_run();
    bus.wrt_smpl = 1'b0;
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    m_n = 0;
    hist.delete();
    m_armed = 1'b0;
    m_post_active = 1'b0;
    m_post = 0;
    m_phase = 1;
    checks++;
    if ({bus.armed, bus.capture_done, bus.waddr} !== {2'b00, {LOG2{1'b0}}}) begin
      errors++;
      $display("FAIL run_start: armed=%b done=%b waddr=%0d want 0 0 0", bus.armed, bus.capture_done, bus.waddr);
    end
  endtask

  // One clock of capture-side stimulus with the model advanced by the spec rules.
  task automatic cap_cycle(input bit strobe, input bit trig);
    bit exp_we;
    bit was_armed;
    bus.wrt_smpl  = strobe;
    bus.triggered = trig;
    wdata = idx_data ? m_n[7:0] : 8'($urandom);
    exp_we = strobe && (m_phase == 1);
    #1;
    checks++;
    if (bus.we !== exp_we) begin
      errors++;
      $display("FAIL we: got %b want %b (n=%0d)", bus.we, exp_we, m_n);
    end
    step();
    bus.wrt_smpl  = 1'b0;
    bus.triggered = 1'b0;
    was_armed = m_armed;
    if (exp_we) begin
      hist.push_back(wdata);
      m_n++;
      if (m_post_active) m_post++;
    end
    if (m_phase == 1) begin
      if (trig && was_armed && !m_post_active) begin
        m_post_active = 1'b1;
        m_post = 0;
      end
      if (m_post_active && m_post == tp_eff) m_phase = 2;
      if (m_n + tp_eff >= ENTRIES) m_armed = 1'b1;
    end
    checks++;
    if (bus.armed !== m_armed) begin
      errors++;
      $display("FAIL armed: got %b want %b (n=%0d tp=%0d)", bus.armed, m_armed, m_n, tp_eff);
    end
    checks++;
    if (bus.capture_done !== (m_phase == 2)) begin
      errors++;
      $display("FAIL capture_done: got %b want %b (n=%0d)", bus.capture_done, (m_phase == 2), m_n);
    end
    checks++;
    if (bus.waddr !== LOG2'(m_n % ENTRIES)) begin
      errors++;
      $display("FAIL waddr: got %0d want %0d", bus.waddr, m_n % ENTRIES);
    end
  endtask

  task automatic run_until_armed(input int pct);
    int guard = 0;
    while (!m_armed && guard < 5000) begin
      cap_cycle($urandom_range(99) < pct, 1'b0);
      guard++;
    end
    checks++;
    if (!m_armed) begin
      errors++;
      $display("FAIL arm_timeout: armed=%b want 1", bus.armed);
    end
  endtask

  task automatic run_until_done(input int pct);
    int guard = 0;
    while (m_phase == 1 && guard < 5000) begin
      cap_cycle($urandom_range(99) < pct, 1'b0);
      guard++;
    end
    checks++;
    if (bus.capture_done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: capture_done=%b want 1", bus.capture_done);
    end
  endtask

  // Streams the buffer; expected byte i is the i-th of the newest ENTRIES samples.
  task automatic do_dump(input int stall_byte, input int stall_len, input int rdy_pct);
    int  base, off, i, stall, cyc, done0;
    bit  rdy, vld_now, hold;
    base = m_n % ENTRIES;
    off  = hist.size() - ENTRIES;
    done0 = done_cnt;
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
    i = 0; stall = 0; cyc = 0; hold = 1'b0;
    while (i < ENTRIES && cyc < 6000) begin
      vld_now = (bus.dump_vld === 1'b1);
      checks++;
      if (bus.dump_done !== 1'b0) begin
        errors++;
        $display("FAIL dump_done_early: got %b want 0 at byte %0d", bus.dump_done, i);
      end
      if (hold) begin
        checks++;
        if (!vld_now) begin
          errors++;
          $display("FAIL vld_hold: dump_vld=%b want 1 at byte %0d", bus.dump_vld, i);
        end
      end
      if (vld_now) begin
        checks++;
        if (bus.raddr !== LOG2'((base + i) % ENTRIES)) begin
          errors++;
          $display("FAIL raddr: got %0d want %0d at byte %0d", bus.raddr, (base + i) % ENTRIES, i);
        end
        checks++;
        if (rdata !== hist[off + i]) begin
          errors++;
          $display("FAIL dump_byte: got %0h want %0h at byte %0d", rdata, hist[off + i], i);
        end
        if (i == stall_byte && stall < stall_len) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = ($urandom_range(99) < rdy_pct);
        end
      end else begin
        rdy = 1'($urandom_range(1));
      end
      hold = vld_now && !rdy;
      bus.dump_rdy = rdy;
      step();
      if (vld_now && rdy) i++;
      cyc++;
    end
    bus.dump_rdy = 1'b0;
    checks++;
    if (i != ENTRIES) begin
      errors++;
      $display("FAIL dump_timeout: bytes=%0d want %0d", i, ENTRIES);
    end
    checks++;
    if ({bus.dump_done, bus.capture_done, bus.dump_vld} !== 3'b100) begin
      errors++;
      $display("FAIL dump_end: done/cap/vld=%b%b%b want 100", bus.dump_done, bus.capture_done, bus.dump_vld);
    end
    step();
    checks++;
    if (bus.dump_done !== 1'b0 || done_cnt != done0 + 1) begin
      errors++;
      $display("FAIL dump_done_pulse: dump_done=%b pulses=%0d want 0 and 1", bus.dump_done, done_cnt - done0);
    end
    m_phase = 0;
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.triggered = 1'b0;
    bus.dump_req = 1'b0; bus.dump_rdy = 1'b0; bus.trig_pos = '0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.we, bus.armed, bus.capture_done, bus.dump_vld, bus.dump_done, bus.waddr, bus.raddr} !== '0) begin
      errors++;
      $display("FAIL reset_state: we=%b armed=%b done=%b vld=%b ddone=%b waddr=%0d raddr=%0d want all 0",
               bus.we, bus.armed, bus.capture_done, bus.dump_vld, bus.dump_done, bus.waddr, bus.raddr);
    end
    rst = 1'b0;
    m_phase = 0; m_n = 0;
    cap_cycle(1'b1, 1'b1);
  endtask

  task automatic test_arm_timing();
    int snap, tstamp;
    idx_data = 1'b0;
    set_tp(100);
    start_run();
    while (m_n < 283) cap_cycle(1'b1, 1'b0);
    checks++;
    if (bus.armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_283: got %b want 0", bus.armed);
    end
    cap_cycle(1'b1, 1'b0);
    checks++;
    if (bus.armed !== 1'b1) begin
      errors++;
      $display("FAIL arm_284: got %b want 1", bus.armed);
    end
    cap_cycle(1'b0, 1'b1);
    snap = we_cnt;
    tstamp = m_n;
    run_until_done(100);
    repeat (10) cap_cycle(1'b1, 1'b0);
    checks++;
    if (we_cnt - snap != 100) begin
      errors++;
      $display("FAIL post_writes: got %0d want 100", we_cnt - snap);
    end
    checks++;
    if (bus.waddr !== LOG2'((tstamp + 100) % ENTRIES)) begin
      errors++;
      $display("FAIL post_waddr: got %0d want %0d", bus.waddr, (tstamp + 100) % ENTRIES);
    end
    // run is ignored once the buffer is frozen.
    snap = int'(bus.waddr);
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    checks++;
    if ({bus.capture_done, bus.armed} !== 2'b11 || int'(bus.waddr) != snap) begin
      errors++;
      $display("FAIL run_in_done: done=%b armed=%b waddr=%0d want 1 1 %0d", bus.capture_done, bus.armed, bus.waddr, snap);
    end
    do_dump(-1, 0, 60);
  endtask

  task automatic test_early_trigger();
    set_tp(int'($urandom_range(50, 200)));
    start_run();
    repeat (20) cap_cycle(1'b1, 1'b0);
    cap_cycle(1'b1, 1'b1);
    checks++;
    if ({bus.armed, bus.capture_done} !== 2'b00) begin
      errors++;
      $display("FAIL early_trig: armed=%b done=%b want 0 0", bus.armed, bus.capture_done);
    end
    // dump_req while capturing must not start a dump.
    bus.dump_req = 1'b1;
    cap_cycle(1'b1, 1'b0);
    bus.dump_req = 1'b0;
    cap_cycle(1'b0, 1'b0);
    checks++;
    if (bus.dump_vld !== 1'b0) begin
      errors++;
      $display("FAIL dump_req_ignored: dump_vld=%b want 0", bus.dump_vld);
    end
    run_until_armed(70);
    cap_cycle(1'($urandom_range(1)), 1'b1);
    run_until_done(70);
    do_dump(-1, 0, 50);
  endtask

  task automatic test_trig_pos_zero();
    int snap;
    set_tp(0);
    start_run();
    run_until_armed(80);
    cap_cycle(1'b1, 1'b1);
    checks++;
    if (bus.capture_done !== 1'b1 || bus.waddr !== LOG2'(m_n % ENTRIES)) begin
      errors++;
      $display("FAIL tp0_done: done=%b waddr=%0d want 1 %0d", bus.capture_done, bus.waddr, m_n % ENTRIES);
    end
    snap = we_cnt;
    repeat (5) cap_cycle(1'b1, 1'b0);
    checks++;
    if (we_cnt != snap) begin
      errors++;
      $display("FAIL tp0_nowrite: writes=%0d want 0", we_cnt - snap);
    end
    do_dump(-1, 0, 100);
  endtask

  task automatic test_clamp();
    set_tp(450);
    start_run();
    repeat (5) cap_cycle(1'b1, 1'b0);
    cap_cycle(1'b0, 1'b1);
    run_until_done(90);
    checks++;
    if (m_n != 5 + (ENTRIES - 1)) begin
      errors++;
      $display("FAIL clamp_model: samples=%0d want %0d", m_n, 5 + ENTRIES - 1);
    end
    do_dump(-1, 0, 70);
  endtask

  task automatic test_restart();
    set_tp(50);
    start_run();
    repeat (100) cap_cycle(1'b1, 1'b0);
    start_run();
    run_until_armed(100);
    cap_cycle(1'b0, 1'b1);
    repeat (10) cap_cycle(1'b1, 1'b0);
    start_run();
    run_until_armed(60);
    cap_cycle(1'b1, 1'b1);
    run_until_done(60);
    do_dump(-1, 0, 80);
  endtask

  task automatic test_long_wrap_stall();
    int guard = 0;
    idx_data = 1'b1;
    set_tp(int'($urandom_range(1, 300)));
    start_run();
    while (m_n < 1000 && guard < 5000) begin
      cap_cycle($urandom_range(99) < 75, 1'b0);
      guard++;
    end
    cap_cycle(1'b0, 1'b1);
    run_until_done(75);
    do_dump(10, 5, 100);
    idx_data = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int guard = 0;
    set_tp(20);
    start_run();
    run_until_armed(100);
    cap_cycle(1'b1, 1'b1);
    run_until_done(100);
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
    bus.dump_rdy = 1'b0;
    while (bus.dump_vld !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    bus.wrt_smpl = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.we, bus.armed, bus.capture_done, bus.dump_vld, bus.dump_done, bus.waddr, bus.raddr} !== '0) begin
      errors++;
      $display("FAIL async_reset: we=%b armed=%b done=%b vld=%b ddone=%b waddr=%0d raddr=%0d want all 0",
               bus.we, bus.armed, bus.capture_done, bus.dump_vld, bus.dump_done, bus.waddr, bus.raddr);
    end
    bus.wrt_smpl = 1'b0;
    step();
    rst = 1'b0;
    m_phase = 0; m_n = 0; m_armed = 1'b0; m_post_active = 1'b0;
    bus.dump_req = 1'b1;
    cap_cycle(1'b1, 1'b0);
    bus.dump_req = 1'b0;
    cap_cycle(1'b0, 1'b0);
    checks++;
    if (bus.dump_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_dump_req: dump_vld=%b want 0", bus.dump_vld);
    end
    start_run();
    repeat (5) cap_cycle(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arm_timing();
    test_early_trigger();
    test_trig_pos_zero();
    test_clamp();
    test_restart();
    test_long_wrap_stall();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
